// File: rtl/spiox_pkg.sv
// Shared constants for the spiox special-purpose I/O peripheral:
// register map, event bit offsets and the maximum LED/button count.
package spiox_pkg;

  typedef enum logic [1:0] {
    ADR_LED = 2'd0,
    ADR_BTN = 2'd1,
    ADR_IEN = 2'd2,
    ADR_EVT = 2'd3
  } spiox_adr_e;

  localparam int PRESS_LSB   = 0;
  localparam int RELEASE_LSB = 8;
  localparam int MAX_IO      = 8;

endpackage

// File: rtl/spiox_debounce.sv
// One button channel: 2FF synchroniser, saturating debounce counter,
// stable level and single-cycle rise/fall pulses coincident with the level change.
module spiox_debounce #(
  parameter int DB_LGCNT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                r_meta;
  logic                r_sync;
  logic                r_level;
  logic [DB_LGCNT-1:0] r_cnt;
  logic                w_diff;
  logic                w_sat;

  assign w_diff = r_sync ^ r_level;
  assign w_sat  = (r_cnt == {DB_LGCNT{1'b1}});

  // Level only flips after the synced input has disagreed with it for a full window
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= {DB_LGCNT{1'b0}};
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_diff) begin
        r_cnt <= {DB_LGCNT{1'b0}};
      end else if (w_sat) begin
        r_level <= ~r_level;
        r_cnt   <= {DB_LGCNT{1'b0}};
      end else begin
        r_cnt <= r_cnt + DB_LGCNT'(1);
      end
    end
  end

  assign o_sync  = r_sync;
  assign o_level = r_level;
  assign o_rise  = w_diff & w_sat & ~r_level;
  assign o_fall  = w_diff & w_sat & r_level;

endmodule

// File: rtl/spiox.sv
// spiox: Wishbone LED/button peripheral with debounced sticky events and masked interrupt.
// Optional hardware LED blink engine enabled by defining SPIOX_BLINK_EN.
module spiox
  import spiox_pkg::*;
#(
  parameter int NLED     = 4,
  parameter int NBTN     = 4,
  parameter int DB_LGCNT = 16,
  parameter int BLINK_LG = 22
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [1:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NBTN-1:0] i_btn,
  output logic [NLED-1:0] o_led,
  output logic            o_int
);

  logic [1:0] r_rst_pipe;
  logic       w_rst;

  // Reset asserts immediately, releases two clocks after i_reset drops
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end
  assign w_rst = r_rst_pipe[1];

  logic [NBTN-1:0] w_sync, w_level, w_rise, w_fall;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    spiox_debounce #(.DB_LGCNT(DB_LGCNT)) u_db (
      .i_clk   (i_clk),
      .i_rst   (w_rst),
      .i_raw   (i_btn[g]),
      .o_sync  (w_sync[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  logic       w_stb, w_wr, w_led_wr;
  spiox_adr_e w_adr;

  assign w_stb    = i_wb_cyc & i_wb_stb;
  assign w_wr     = w_stb & i_wb_we;
  assign w_adr    = spiox_adr_e'(i_wb_addr);
  assign w_led_wr = w_wr & (w_adr == ADR_LED) & i_wb_sel[1] & i_wb_sel[0];

  logic [NLED-1:0] r_led, w_led_nxt;
  logic [NBTN-1:0] r_ienp, r_ienr, r_evtp, r_evtr;
  logic [NBTN-1:0] w_ienp_nxt, w_ienr_nxt, w_evtp_nxt, w_evtr_nxt, w_clrp, w_clrr;
  logic            r_ack, r_int;
  logic [31:0]     r_rdata, w_rdata;

  // Next-state for LED, mask and event registers; a new edge beats a same-cycle clear
  always_comb begin
    w_led_nxt = r_led;
    for (int k = 0; k < NLED; k++) begin
      if (w_led_wr && i_wb_data[8+k]) begin
        w_led_nxt[k] = i_wb_data[k];
      end else begin
        w_led_nxt[k] = r_led[k];
      end
    end
    w_ienp_nxt = r_ienp;
    w_ienr_nxt = r_ienr;
    if (w_wr && (w_adr == ADR_IEN) && i_wb_sel[0]) begin
      w_ienp_nxt = i_wb_data[PRESS_LSB +: NBTN];
    end else begin
      w_ienp_nxt = r_ienp;
    end
    if (w_wr && (w_adr == ADR_IEN) && i_wb_sel[1]) begin
      w_ienr_nxt = i_wb_data[RELEASE_LSB +: NBTN];
    end else begin
      w_ienr_nxt = r_ienr;
    end
    w_clrp = {NBTN{1'b0}};
    w_clrr = {NBTN{1'b0}};
    if (w_wr && (w_adr == ADR_EVT) && i_wb_sel[0]) begin
      w_clrp = i_wb_data[PRESS_LSB +: NBTN];
    end else begin
      w_clrp = {NBTN{1'b0}};
    end
    if (w_wr && (w_adr == ADR_EVT) && i_wb_sel[1]) begin
      w_clrr = i_wb_data[RELEASE_LSB +: NBTN];
    end else begin
      w_clrr = {NBTN{1'b0}};
    end
    w_evtp_nxt = (r_evtp & ~w_clrp) | w_rise;
    w_evtr_nxt = (r_evtr & ~w_clrr) | w_fall;
  end

  logic [MAX_IO-1:0] w_led8, w_blink8, w_sync8, w_lvl8;
  logic [MAX_IO-1:0] w_ienp8, w_ienr8, w_evtp8, w_evtr8;
  logic              w_unused;

`ifdef SPIOX_BLINK_EN
  logic [NLED-1:0]   r_blink, w_blink_nxt, r_led_out;
  logic [BLINK_LG:0] r_presc, w_presc_nxt;

  assign w_presc_nxt = r_presc + (BLINK_LG+1)'(1);

  // Blink enables live in byte 2 of the LED register
  always_comb begin
    w_blink_nxt = r_blink;
    if (w_wr && (w_adr == ADR_LED) && i_wb_sel[2]) begin
      w_blink_nxt = i_wb_data[16 +: NLED];
    end else begin
      w_blink_nxt = r_blink;
    end
    w_blink8 = {MAX_IO{1'b0}};
    for (int k = 0; k < NLED; k++) begin
      w_blink8[k] = r_blink[k];
    end
  end

  // Output is computed from next-state so blink enable/disable takes effect at once
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_blink   <= {NLED{1'b0}};
      r_presc   <= {(BLINK_LG+1){1'b0}};
      r_led_out <= {NLED{1'b0}};
    end else begin
      r_blink   <= w_blink_nxt;
      r_presc   <= w_presc_nxt;
      r_led_out <= w_led_nxt ^ (w_blink_nxt & {NLED{w_presc_nxt[BLINK_LG]}});
    end
  end

  assign o_led    = r_led_out;
  assign w_unused = ^{i_wb_data, i_wb_sel};
`else
  assign w_blink8 = {MAX_IO{1'b0}};
  assign o_led    = r_led;
  assign w_unused = (^{i_wb_data, i_wb_sel}) ^ (BLINK_LG > 0);
`endif

  // Zero-pad every field to a full byte for the read mux
  always_comb begin
    w_led8  = {MAX_IO{1'b0}};
    w_sync8 = {MAX_IO{1'b0}};
    w_lvl8  = {MAX_IO{1'b0}};
    w_ienp8 = {MAX_IO{1'b0}};
    w_ienr8 = {MAX_IO{1'b0}};
    w_evtp8 = {MAX_IO{1'b0}};
    w_evtr8 = {MAX_IO{1'b0}};
    for (int k = 0; k < NLED; k++) begin
      w_led8[k] = r_led[k];
    end
    for (int k = 0; k < NBTN; k++) begin
      w_sync8[k] = w_sync[k];
      w_lvl8[k]  = w_level[k];
      w_ienp8[k] = r_ienp[k];
      w_ienr8[k] = r_ienr[k];
      w_evtp8[k] = r_evtp[k];
      w_evtr8[k] = r_evtr[k];
    end
  end

  // Read data mux
  always_comb begin
    w_rdata = 32'h0;
    case (w_adr)
      ADR_LED: w_rdata = {16'h0, w_blink8, w_led8};
      ADR_BTN: w_rdata = {16'h0, w_sync8, w_lvl8};
      ADR_IEN: w_rdata = {16'h0, w_ienr8, w_ienp8};
      ADR_EVT: w_rdata = {16'h0, w_evtr8, w_evtp8};
      default: w_rdata = 32'h0;
    endcase
  end

  // Register file, bus response and interrupt
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_led   <= {NLED{1'b0}};
      r_ienp  <= {NBTN{1'b0}};
      r_ienr  <= {NBTN{1'b0}};
      r_evtp  <= {NBTN{1'b0}};
      r_evtr  <= {NBTN{1'b0}};
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
      r_int   <= 1'b0;
    end else begin
      r_led   <= w_led_nxt;
      r_ienp  <= w_ienp_nxt;
      r_ienr  <= w_ienr_nxt;
      r_evtp  <= w_evtp_nxt;
      r_evtr  <= w_evtr_nxt;
      r_ack   <= w_stb;
      r_rdata <= w_stb ? w_rdata : 32'h0;
      r_int   <= (|(r_evtp & r_ienp)) | (|(r_evtr & r_ienr));
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_rdata;
  assign o_int      = r_int;

endmodule

// File: tb/tb_spiox.sv
// Self-checking bench for spiox: directed steps plus randomized LED/IEN/EVT/button traffic
// compared against a register-level behavioural model.
module tb_spiox;
  import spiox_pkg::*;

  localparam int NLED = 4;
  localparam int NBTN = 4;
  localparam int DBL  = 4;
  localparam int BLL  = 4;
  localparam int DBW  = 1 << DBL;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc, stb, we;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [3:0]      sel;
  logic            stall, ack;
  logic [31:0]     rdata;
  logic [NBTN-1:0] btn;
  logic [NLED-1:0] led;
  logic            irq;

  always #5 clk = ~clk;

  spiox #(.NLED(NLED), .NBTN(NBTN), .DB_LGCNT(DBL), .BLINK_LG(BLL)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall),
    .o_wb_ack(ack), .o_wb_data(rdata), .i_btn(btn), .o_led(led), .o_int(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [NLED-1:0] m_led;
  logic [NBTN-1:0] m_lvl, m_evp, m_evr, m_ienp, m_ienr;
  logic [7:0]      m_blink8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack", {31'h0, ack}, 32'h1);
    r = rdata;
  endtask

  function automatic logic [31:0] exp_led();
    return {16'h0, m_blink8, 4'h0, m_led};
  endfunction
  function automatic logic [31:0] exp_btn();
    return {16'h0, 4'h0, btn, 4'h0, m_lvl};
  endfunction
  function automatic logic [31:0] exp_evt();
    return {16'h0, 4'h0, m_evr, 4'h0, m_evp};
  endfunction
  function automatic logic [31:0] exp_ien();
    return {16'h0, 4'h0, m_ienr, 4'h0, m_ienp};
  endfunction
  function automatic logic exp_int();
    return (|(m_evp & m_ienp)) | (|(m_evr & m_ienr));
  endfunction

  task automatic m_led_wr(input logic [31:0] d, input logic [3:0] s);
    if (s[1] && s[0])
      for (int k = 0; k < NLED; k++) if (d[8+k]) m_led[k] = d[k];
  endtask
  task automatic m_evt_w1c(input logic [31:0] d, input logic [3:0] s);
    if (s[0]) m_evp = m_evp & ~d[3:0];
    if (s[1]) m_evr = m_evr & ~d[11:8];
  endtask
  task automatic m_ien_wr(input logic [31:0] d, input logic [3:0] s);
    if (s[0]) m_ienp = d[3:0];
    if (s[1]) m_ienr = d[11:8];
  endtask
  // Any level change reaches the debounced level well inside DBW+6 clocks
  task automatic set_btn(input logic [NBTN-1:0] v);
    btn = v;
    tick(DBW + 6);
    for (int k = 0; k < NBTN; k++)
      if (v[k] != m_lvl[k]) begin
        if (v[k]) m_evp[k] = 1'b1; else m_evr[k] = 1'b1;
      end
    m_lvl = v;
  endtask
  task automatic m_reset();
    m_led = '0; m_lvl = '0; m_evp = '0; m_evr = '0; m_ienp = '0; m_ienr = '0; m_blink8 = 8'h0;
  endtask

  initial begin
    logic [31:0] rd, d;
    logic [3:0]  s;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0; sel = 4'h0;
    btn = '0;
    m_reset();
    #12;
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_data", rdata, 32'h0);
    check("rst_int", {31'h0, irq}, 32'h0);
    check("stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4);
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("rst_evt", rd, 32'h0);
    wb(1'b0, ADR_IEN, 32'h0, 4'hF, rd); check("rst_ien", rd, 32'h0);

    // Directed masked LED writes
    wb(1'b1, ADR_LED, 32'h0000_0305, 4'b0011, rd); m_led_wr(32'h0305, 4'b0011);
    check("led_0305", {28'h0, led}, 32'h1);
    wb(1'b1, ADR_LED, 32'h0000_0F00, 4'b0011, rd); m_led_wr(32'h0F00, 4'b0011);
    check("led_0F00", {28'h0, led}, 32'h0);
    wb(1'b1, ADR_LED, 32'h0000_0F0F, 4'b0001, rd); m_led_wr(32'h0F0F, 4'b0001);
    check("led_sel1", {28'h0, led}, 32'h0);

    // Random LED writes
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (i < 3) s = 4'b0011;
      wb(1'b1, ADR_LED, d & 32'h0000_FFFF, s, rd);
      m_led_wr(d, s);
      check("led_rand", {28'h0, led}, {28'h0, m_led});
      wb(1'b0, ADR_LED, 32'h0, 4'hF, rd);
      check("led_read", rd, exp_led());
    end

`ifdef SPIOX_BLINK_EN
    begin
      int last, tog;
      logic prev;
      wb(1'b1, ADR_LED, 32'h0002_0200, 4'b0111, rd);
      m_led_wr(32'h0002_0200, 4'b0111); m_blink8 = 8'h02;
      wb(1'b0, ADR_LED, 32'h0, 4'hF, rd); check("blink_read", rd, exp_led());
      prev = led[1]; last = -1; tog = 0;
      for (int c = 0; c < 80; c++) begin
        tick(1);
        if (led[1] != prev) begin
          if (last >= 0) check("blink_period", 32'(c - last), 32'd16);
          last = c; tog++; prev = led[1];
        end
      end
      check("blink_toggles", {31'h0, tog >= 4}, 32'h1);
      wb(1'b1, ADR_LED, 32'h0, 4'b0100, rd); m_blink8 = 8'h00;
      check("blink_off", {28'h0, led}, {28'h0, m_led});
    end
`else
    wb(1'b1, ADR_LED, 32'h00FF_0000, 4'b1111, rd); m_led_wr(32'h00FF_0000, 4'b1111);
    wb(1'b0, ADR_LED, 32'h0, 4'hF, rd);
    check("byte2_zero", rd, exp_led());
`endif

    // Exact debounce latency and interrupt path on button 2
    wb(1'b1, ADR_IEN, 32'h0000_0004, 4'b0011, rd); m_ien_wr(32'h4, 4'b0011);
    btn[2] = 1'b1;
    tick(DBW + 1);
    wb(1'b0, ADR_BTN, 32'h0, 4'hF, rd); check("db_before", rd, 32'h0000_0400);
    wb(1'b0, ADR_BTN, 32'h0, 4'hF, rd); check("db_edge", rd, 32'h0000_0404);
    m_lvl[2] = 1'b1; m_evp[2] = 1'b1;
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("evt_press", rd, exp_evt());
    check("int_set", {31'h0, irq}, 32'h1);
    wb(1'b1, ADR_EVT, 32'h0000_0004, 4'b0001, rd); m_evt_w1c(32'h4, 4'b0001);
    check("int_hold", {31'h0, irq}, 32'h1);
    tick(1);
    check("int_clr", {31'h0, irq}, {31'h0, exp_int()});

    // W1C coinciding with a fresh press edge keeps the bit set
    set_btn(4'b0000);
    btn[2] = 1'b1;
    tick(DBW + 1);
    wb(1'b1, ADR_EVT, 32'h0000_0004, 4'b0001, rd);
    m_evt_w1c(32'h4, 4'b0001); m_lvl[2] = 1'b1; m_evp[2] = 1'b1;
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("evt_w1c_race", rd, exp_evt());

    // A glitch shorter than the window is filtered
    wb(1'b1, ADR_EVT, 32'h0000_0F0F, 4'b0011, rd); m_evt_w1c(32'h0F0F, 4'b0011);
    btn[0] = 1'b1; tick(DBW - 2); btn[0] = 1'b0; tick(DBW + 6);
    wb(1'b0, ADR_BTN, 32'h0, 4'hF, rd); check("glitch_btn", rd, exp_btn());
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("glitch_evt", rd, exp_evt());

    // Random buttons, masks and clears
    for (int i = 0; i < 8; i++) begin
      set_btn(NBTN'($urandom));
      wb(1'b0, ADR_BTN, 32'h0, 4'hF, rd); check("rnd_btn", rd, exp_btn());
      wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("rnd_evt", rd, exp_evt());
      d = $urandom; s = 4'($urandom_range(0, 15));
      wb(1'b1, ADR_IEN, d, s, rd); m_ien_wr(d, s);
      tick(1);
      check("rnd_int_ien", {31'h0, irq}, {31'h0, exp_int()});
      wb(1'b0, ADR_IEN, 32'h0, 4'hF, rd); check("rnd_ien", rd, exp_ien());
      if (i % 2 == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        wb(1'b1, ADR_EVT, d, s, rd); m_evt_w1c(d, s);
        tick(1);
        check("rnd_int_evt", {31'h0, irq}, {31'h0, exp_int()});
      end
    end

    // Mid-run reset with LEDs lit and EVT=0x0101
    set_btn(4'b0000);
    wb(1'b1, ADR_EVT, 32'h0000_0F0F, 4'b0011, rd); m_evt_w1c(32'h0F0F, 4'b0011);
    wb(1'b1, ADR_LED, 32'h0000_0F0F, 4'b0011, rd); m_led_wr(32'h0F0F, 4'b0011);
    wb(1'b1, ADR_IEN, 32'h0000_0101, 4'b0011, rd); m_ien_wr(32'h0101, 4'b0011);
    set_btn(4'b0001);
    set_btn(4'b0000);
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("pre_rst_evt", rd, 32'h0000_0101);
    tick(1);
    check("pre_rst_int", {31'h0, irq}, 32'h1);
    check("pre_rst_led", {28'h0, led}, 32'hF);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_led", {28'h0, led}, 32'h0);
    check("mid_rst_int", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    tick(4);
    wb(1'b0, ADR_EVT, 32'h0, 4'hF, rd); check("post_rst_evt", rd, exp_evt());
    wb(1'b0, ADR_IEN, 32'h0, 4'hF, rd); check("post_rst_ien", rd, exp_ien());
    wb(1'b0, ADR_LED, 32'h0, 4'hF, rd); check("post_rst_led", rd, exp_led());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
